// File: rtl/pix_fetch.sv
// pix_fetch
//   Avalon-MM pipelined read master that streams one frame of 32-bit pixels,
//   starting at BASE_ADDR and stepping by ADDR_INC, into a first-word
//   fall-through return FIFO. The FIFO drains on a valid/ready pixel port.
//   Reads are credit-limited: a read is only issued while
//   fifo_count + outstanding < FIFO_DEPTH, so returning data always has room.
//
// Configuration macro:
//   PIX_FETCH_LOOP_EN  when defined, the frame repeats forever. The address
//                      reloads BASE_ADDR and ISSUE continues with no idle
//                      cycle. frame_done pulses once per frame and busy stays
//                      high until reset.
//
// Ports:
//   clk              in   system clock, rising edge
//   n_rst            in   asynchronous active-low reset
//   start            in   1-cycle frame request, ignored while busy
//   wait_request     in   Avalon slave stall
//   read             out  Avalon read request
//   read_address     out  Avalon byte address [31:0]
//   read_data        in   Avalon read data [31:0]
//   read_data_valid  in   read data valid (in-order responses)
//   pix_data         out  FIFO head pixel [31:0] (0 when empty)
//   pix_valid        out  FIFO not empty
//   pix_ready        in   consumer accepts pixel when pix_valid & pix_ready
//   busy             out  frame in progress
//   frame_done       out  1-cycle pulse after the frame's last pixel is taken
module pix_fetch #(
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int unsigned NUM_PIXELS = 307200,
  parameter logic [31:0] ADDR_INC   = 32'd4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic        wait_request,
  output logic        read,
  output logic [31:0] read_address,
  input  logic [31:0] read_data,
  input  logic        read_data_valid,
  output logic [31:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned CW      = AW + 1;
  localparam logic [31:0] LP_LAST = 32'(NUM_PIXELS - 1);
  localparam logic [CW:0] LP_DEPTH = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [31:0]   r_addr;
  logic [31:0]   r_issued;
  logic [31:0]   r_accepted;
  logic [CW-1:0] r_outst;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [31:0]   r_mem [FIFO_DEPTH];
  logic          r_frame_done;

  logic          w_empty;
  logic          w_credit;
  logic          w_read;
  logic          w_issue_acc;
  logic          w_last_issue;
  logic          w_push;
  logic          w_pop;
  logic          w_last_pop;

  assign w_empty  = (r_count == '0);
  // Slots still free once every in-flight read has landed.
  assign w_credit = ({1'b0, r_count} + {1'b0, r_outst}) < LP_DEPTH;

  // Only pops and returns change the credit sum while stalled, and neither
  // raises it, so read cannot drop while wait_request holds it.
  assign w_read       = (r_state == S_ISSUE) && w_credit;
  assign w_issue_acc  = w_read && !wait_request;
  assign w_last_issue = (r_issued == LP_LAST);

  // A return with nothing outstanding is a leftover from before reset.
  assign w_push     = read_data_valid && (r_outst != '0);
  assign w_pop      = !w_empty && pix_ready;
  assign w_last_pop = w_pop && (r_accepted == LP_LAST);

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
`ifdef PIX_FETCH_LOOP_EN
        w_state_nxt = S_ISSUE;
`else
        if (w_issue_acc && w_last_issue) begin
          w_state_nxt = S_DRAIN;
        end
`endif
      end
      S_DRAIN: begin
        if (w_last_pop) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Address, counters and FIFO control
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_addr       <= BASE_ADDR;
      r_issued     <= '0;
      r_accepted   <= '0;
      r_outst      <= '0;
      r_count      <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_frame_done <= 1'b0;
    end else begin
      // Counters return to zero and the address to BASE_ADDR at the end of
      // each frame, so the next frame (looped or newly started) is ready.
      if (w_issue_acc) begin
        if (w_last_issue) begin
          r_issued <= '0;
          r_addr   <= BASE_ADDR;
        end else begin
          r_issued <= r_issued + 32'd1;
          r_addr   <= r_addr + ADDR_INC;
        end
      end

      if (w_pop) begin
        r_accepted <= w_last_pop ? '0 : (r_accepted + 32'd1);
        r_rd_ptr   <= r_rd_ptr + AW'(1);
      end

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end

      case ({w_issue_acc, w_push})
        2'b10:   r_outst <= r_outst + CW'(1);
        2'b01:   r_outst <= r_outst - CW'(1);
        default: r_outst <= r_outst;
      endcase

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      r_frame_done <= w_last_pop;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= read_data;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign read         = w_read;
  assign read_address = r_addr;
  assign pix_valid    = !w_empty;
  assign pix_data     = w_empty ? '0 : r_mem[r_rd_ptr];
  assign busy         = (r_state != S_IDLE);
  assign frame_done   = r_frame_done;

endmodule

// File: tb/tb_pix_fetch.sv
// Directed bench for pix_fetch with NUM_PIXELS=20, FIFO_DEPTH=8.
// The memory model returns word (addr/4)+1 one cycle after each accepted read.
module tb_pix_fetch;

  localparam int NPIX = 20;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        start = 1'b0;
  logic        wait_request = 1'b0;
  logic        read;
  logic [31:0] read_address;
  logic [31:0] read_data = '0;
  logic        read_data_valid = 1'b0;
  logic [31:0] pix_data;
  logic        pix_valid;
  logic        pix_ready = 1'b1;
  logic        busy;
  logic        frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] resp_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] rx_q[$];
  int          fd_cnt = 0;
  logic        fd_busy = 1'b0;

  pix_fetch #(
    .BASE_ADDR (32'h0),
    .NUM_PIXELS(NPIX),
    .ADDR_INC  (32'd4),
    .FIFO_DEPTH(8)
  ) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .start          (start),
    .wait_request   (wait_request),
    .read           (read),
    .read_address   (read_address),
    .read_data      (read_data),
    .read_data_valid(read_data_valid),
    .pix_data       (pix_data),
    .pix_valid      (pix_valid),
    .pix_ready      (pix_ready),
    .busy           (busy),
    .frame_done     (frame_done)
  );

  always #5 clk = ~clk;

  // Memory slave and output monitor, evaluated mid-cycle after stimulus.
  always @(negedge clk) begin
    #1;
    if (resp_q.size() > 0) begin
      read_data_valid = 1'b1;
      read_data       = resp_q.pop_front();
    end else begin
      read_data_valid = 1'b0;
      read_data       = '0;
    end
    if (read && !wait_request) begin
      addr_q.push_back(read_address);
      resp_q.push_back((read_address >> 2) + 32'd1);
    end
    if (pix_valid && pix_ready) rx_q.push_back(pix_data);
    if (frame_done) begin
      fd_cnt  = fd_cnt + 1;
      fd_busy = busy;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, need $finish)");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic clear_logs();
    addr_q.delete();
    rx_q.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++; if (read !== 1'b0) begin n_fail++; $display("FAIL rst_read got %0b need 0", read); end
    n_tests++; if (read_address !== 32'h0) begin n_fail++; $display("FAIL rst_addr got %h need 0", read_address); end
    n_tests++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL rst_pix_valid got %0b need 0", pix_valid); end
    n_tests++; if (pix_data !== 32'h0) begin n_fail++; $display("FAIL rst_pix_data got %h need 0", pix_data); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %0b need 0", busy); end
    n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_frame_done got %0b need 0", frame_done); end
    n_rst = 1'b1;
    cycles(2);
  endtask

  task automatic test_basic();
    int fd0;
    logic [31:0] got;
    clear_logs();
    fd0 = fd_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %0b need 1", busy); end
    n_tests++; if (read !== 1'b1) begin n_fail++; $display("FAIL basic_first_read got %0b need 1", read); end
    n_tests++; if (read_address !== 32'h0) begin n_fail++; $display("FAIL basic_first_addr got %h need 0", read_address); end
    for (int i = 0; i < 400; i++) begin
      if (fd_cnt != fd0) break;
      @(negedge clk);
    end
    cycles(4);
    n_tests++; if (fd_cnt !== fd0 + 1) begin n_fail++; $display("FAIL basic_frame_done_count got %0d need %0d", fd_cnt - fd0, 1); end
    n_tests++; if (fd_busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done got %0b need 0", fd_busy); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after got %0b need 0", busy); end
    n_tests++; if (addr_q.size() !== NPIX) begin n_fail++; $display("FAIL basic_read_count got %0d need %0d", addr_q.size(), NPIX); end
    for (int i = 0; i < 4; i++) begin
      got = (i < addr_q.size()) ? addr_q[i] : 32'hxxxxxxxx;
      n_tests++; if (got !== 32'(4 * i)) begin n_fail++; $display("FAIL basic_addr[%0d] got %h need %h", i, got, 32'(4 * i)); end
    end
    n_tests++; if (rx_q.size() !== NPIX) begin n_fail++; $display("FAIL basic_pix_count got %0d need %0d", rx_q.size(), NPIX); end
    for (int i = 0; i < NPIX; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 32'hxxxxxxxx;
      n_tests++; if (got !== 32'(i + 1)) begin n_fail++; $display("FAIL basic_pix[%0d] got %h need %h", i, got, 32'(i + 1)); end
    end
  endtask

  task automatic test_wait_request();
    int fd0;
    logic [31:0] got;
    clear_logs();
    fd0 = fd_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    wait_request = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_tests++; if (read !== 1'b1 || read_address !== 32'h4) begin
        n_fail++; $display("FAIL wait_hold[%0d] got read=%0b addr=%h need read=1 addr=4", i, read, read_address);
      end
      @(negedge clk);
    end
    wait_request = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (fd_cnt != fd0) break;
      @(negedge clk);
    end
    cycles(4);
    n_tests++; if (fd_cnt !== fd0 + 1) begin n_fail++; $display("FAIL wait_frame_done got %0d need 1", fd_cnt - fd0); end
    n_tests++; if (addr_q.size() !== NPIX) begin n_fail++; $display("FAIL wait_read_count got %0d need %0d", addr_q.size(), NPIX); end
    n_tests++; if (rx_q.size() !== NPIX) begin n_fail++; $display("FAIL wait_pix_count got %0d need %0d", rx_q.size(), NPIX); end
    for (int i = 0; i < NPIX; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 32'hxxxxxxxx;
      n_tests++; if (got !== 32'(i + 1)) begin n_fail++; $display("FAIL wait_pix[%0d] got %h need %h", i, got, 32'(i + 1)); end
    end
  endtask

  // Full FIFO under stall, then a start that must be ignored while busy.
  task automatic test_backpressure();
    int fd0;
    logic [31:0] got;
    clear_logs();
    fd0 = fd_cnt;
    pix_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles(30);
    n_tests++; if (addr_q.size() !== 8) begin n_fail++; $display("FAIL bp_reads_accepted got %0d need 8", addr_q.size()); end
    n_tests++; if (read !== 1'b0) begin n_fail++; $display("FAIL bp_read_stalled got %0b need 0", read); end
    n_tests++; if (pix_valid !== 1'b1 || pix_data !== 32'h1) begin
      n_fail++; $display("FAIL bp_head got valid=%0b data=%h need valid=1 data=1", pix_valid, pix_data);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pix_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (fd_cnt != fd0) break;
      @(negedge clk);
    end
    cycles(6);
    n_tests++; if (fd_cnt !== fd0 + 1) begin n_fail++; $display("FAIL bp_frame_done got %0d need 1", fd_cnt - fd0); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_busy_after got %0b need 0", busy); end
    n_tests++; if (rx_q.size() !== NPIX) begin n_fail++; $display("FAIL bp_pix_count got %0d need %0d", rx_q.size(), NPIX); end
    for (int i = 0; i < NPIX; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 32'hxxxxxxxx;
      n_tests++; if (got !== 32'(i + 1)) begin n_fail++; $display("FAIL bp_pix[%0d] got %h need %h", i, got, 32'(i + 1)); end
    end
  endtask

  task automatic test_toggle_ready();
    int fd0;
    logic [15:0] pat;
    logic [31:0] got;
    clear_logs();
    fd0 = fd_cnt;
    pat = 16'b1011_0010_1100_0101;
    pix_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles(12);
    for (int i = 0; i < 400; i++) begin
      if (fd_cnt != fd0) break;
      pix_ready = pat[i % 16];
      @(negedge clk);
    end
    pix_ready = 1'b1;
    cycles(4);
    n_tests++; if (fd_cnt !== fd0 + 1) begin n_fail++; $display("FAIL tog_frame_done got %0d need 1", fd_cnt - fd0); end
    n_tests++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL tog_empty_after got %0b need 0", pix_valid); end
    n_tests++; if (rx_q.size() !== NPIX) begin n_fail++; $display("FAIL tog_pix_count got %0d need %0d", rx_q.size(), NPIX); end
    for (int i = 0; i < NPIX; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 32'hxxxxxxxx;
      n_tests++; if (got !== 32'(i + 1)) begin n_fail++; $display("FAIL tog_pix[%0d] got %h need %h", i, got, 32'(i + 1)); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int fd0;
    logic [31:0] got;
    clear_logs();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles(4);
    n_rst = 1'b0;
    #2;
    n_tests++; if (read !== 1'b0 || busy !== 1'b0 || pix_valid !== 1'b0 || read_address !== 32'h0) begin
      n_fail++; $display("FAIL midrst_zero got read=%0b busy=%0b valid=%0b addr=%h need 0 0 0 0", read, busy, pix_valid, read_address);
    end
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    resp_q.push_back(32'hBAD0_0001);
    resp_q.push_back(32'hBAD0_0002);
    rx_q.delete();
    cycles(5);
    n_tests++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_stale_dropped got %0b need 0", pix_valid); end
    n_tests++; if (rx_q.size() !== 0) begin n_fail++; $display("FAIL midrst_stale_rx got %0d need 0", rx_q.size()); end
    clear_logs();
    fd0 = fd_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (fd_cnt != fd0) break;
      @(negedge clk);
    end
    cycles(4);
    got = (addr_q.size() > 0) ? addr_q[0] : 32'hxxxxxxxx;
    n_tests++; if (got !== 32'h0) begin n_fail++; $display("FAIL midrst_refetch_addr got %h need 0", got); end
    n_tests++; if (rx_q.size() !== NPIX) begin n_fail++; $display("FAIL midrst_pix_count got %0d need %0d", rx_q.size(), NPIX); end
    for (int i = 0; i < NPIX; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 32'hxxxxxxxx;
      n_tests++; if (got !== 32'(i + 1)) begin n_fail++; $display("FAIL midrst_pix[%0d] got %h need %h", i, got, 32'(i + 1)); end
    end
  endtask

  task automatic test_back_to_back();
    int fd0;
    logic [31:0] got;
    clear_logs();
    fd0 = fd_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (frame_done === 1'b1) break;
      @(negedge clk);
    end
    n_tests++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL b2b_first_done got %0b need 1", frame_done); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_tests++; if (busy !== 1'b1 || read !== 1'b1 || read_address !== 32'h0) begin
      n_fail++; $display("FAIL b2b_restart got busy=%0b read=%0b addr=%h need 1 1 0", busy, read, read_address);
    end
    for (int i = 0; i < 400; i++) begin
      if (fd_cnt == fd0 + 2) break;
      @(negedge clk);
    end
    cycles(4);
    n_tests++; if (fd_cnt !== fd0 + 2) begin n_fail++; $display("FAIL b2b_frame_done got %0d need 2", fd_cnt - fd0); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_after got %0b need 0", busy); end
    n_tests++; if (rx_q.size() !== 2 * NPIX) begin n_fail++; $display("FAIL b2b_pix_count got %0d need %0d", rx_q.size(), 2 * NPIX); end
    for (int i = 0; i < NPIX; i++) begin
      got = (NPIX + i < rx_q.size()) ? rx_q[NPIX + i] : 32'hxxxxxxxx;
      n_tests++; if (got !== 32'(i + 1)) begin n_fail++; $display("FAIL b2b_pix2[%0d] got %h need %h", i, got, 32'(i + 1)); end
    end
  endtask

  task automatic test_loop();
    int fd0;
    logic [31:0] got;
    clear_logs();
    fd0 = fd_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (fd_cnt == fd0 + 2) break;
      @(negedge clk);
    end
    n_tests++; if (fd_cnt !== fd0 + 2) begin n_fail++; $display("FAIL loop_frame_done got %0d need 2", fd_cnt - fd0); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL loop_busy got %0b need 1", busy); end
    for (int i = 0; i < 3; i++) begin
      got = (NPIX + i < addr_q.size()) ? addr_q[NPIX + i] : 32'hxxxxxxxx;
      n_tests++; if (got !== 32'(4 * i)) begin n_fail++; $display("FAIL loop_addr[%0d] got %h need %h", i, got, 32'(4 * i)); end
    end
    for (int i = 0; i < 2 * NPIX; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 32'hxxxxxxxx;
      n_tests++; if (got !== 32'((i % NPIX) + 1)) begin n_fail++; $display("FAIL loop_pix[%0d] got %h need %h", i, got, 32'((i % NPIX) + 1)); end
    end
  endtask

  initial begin
    test_reset();
`ifdef PIX_FETCH_LOOP_EN
    test_loop();
`else
    test_basic();
    test_wait_request();
    test_backpressure();
    test_toggle_ready();
    test_reset_mid_frame();
    test_back_to_back();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
